// File: rtl/dmem_wbuf.sv
// Store write buffer between M stage and data RAM: FIFO drain over valid/ready, load forwarding.
// Optional store coalescing into the youngest entry when WBUF_COALESCE_EN is defined.
module dmem_wbuf #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memwriteM,
    input  logic          memreadM,
    input  logic [AW-1:0] aluoutM,
    input  logic [31:0]   writedataM,
    output logic [31:0]   readdataM,
    output logic          stall_M,
    output logic [AW-1:0] mem_raddr,
    input  logic [31:0]   mem_rdata,
    output logic          mem_wvalid,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_wready,
    output logic          wbuf_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid;
    logic [AW-3:0]    addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW:0]      count;

    logic [AW-3:0] waddr;
    logic          full;
    logic          pop_now;
    logic          coal;
    logic          alloc;
    logic          fwd_hit;
    logic [31:0]   fwd_data;
    logic          unused_offset;

    assign waddr         = aluoutM[AW-1:2];
    assign unused_offset = ^aluoutM[1:0];

    assign full       = (count == (PW+1)'(DEPTH));
    assign wbuf_empty = (count == '0);
    assign mem_wvalid = !wbuf_empty;
    assign mem_waddr  = {addr_q[head], 2'b00};
    assign mem_wdata  = data_q[head];
    assign mem_raddr  = {waddr, 2'b00};
    assign pop_now    = mem_wvalid && mem_wready;

`ifdef WBUF_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail - PW'(1);
    // The youngest entry cannot absorb a store while it is leaving as the head.
    assign coal = memwriteM && valid[youngest] && (addr_q[youngest] == waddr)
                  && !((youngest == head) && pop_now);
`else
    assign coal = 1'b0;
`endif

    assign alloc   = memwriteM && !coal && (!full || pop_now);
    assign stall_M = memwriteM && !coal && full && !mem_wready;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = head;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && (addr_q[idx] == waddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign readdataM = (memreadM && fwd_hit) ? fwd_data : mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // Pop before push: when full, both touch the same slot and the push must win.
            if (pop_now) begin
                valid[head] <= 1'b0;
                head        <= head + PW'(1);
            end
            if (alloc) begin
                valid[tail]  <= 1'b1;
                addr_q[tail] <= waddr;
                data_q[tail] <= writedataM;
                tail         <= tail + PW'(1);
            end
`ifdef WBUF_COALESCE_EN
            if (coal) begin
                data_q[youngest] <= writedataM;
            end
`endif
            case ({alloc, pop_now})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed self-checking bench for dmem_wbuf: fill/stall, forwarding, streaming, wrap, reset mid-drain.
module tb_dmem_wbuf;

    localparam int AW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwriteM;
    logic          memreadM;
    logic [AW-1:0] aluoutM;
    logic [31:0]   writedataM;
    logic [31:0]   readdataM;
    logic          stall_M;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;
    logic          mem_wvalid;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic          mem_wready;
    logic          wbuf_empty;

    always #5 clk = ~clk;

    dmem_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .memwriteM  (memwriteM),
        .memreadM   (memreadM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .readdataM  (readdataM),
        .stall_M    (stall_M),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_wvalid (mem_wvalid),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_wready (mem_wready),
        .wbuf_empty (wbuf_empty)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RAM-side write log; inputs only change just after posedge, so negedge sees the handshake.
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];
    always @(negedge clk) begin
        if (reset && mem_wvalid && mem_wready) begin
            log_addr.push_back(mem_waddr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memwriteM = 1'b0;
        memreadM  = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwriteM  = 1'b1;
        memreadM   = 1'b0;
        aluoutM    = a;
        writedataM = d;
    endtask

    task automatic drain(input int budget);
        idle();
        mem_wready = 1'b1;
        for (int k = 0; k < budget && !wbuf_empty; k++) cyc();
        check("drain_done", wbuf_empty, 1'b1);
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, log_addr[idx], a);
            check({tag, "_data"}, log_data[idx], d);
        end else begin
            check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        reset      = 1'b0;
        memwriteM  = 1'b0;
        memreadM   = 1'b1;
        aluoutM    = 32'h40;
        writedataM = '0;
        mem_rdata  = 32'hCAFE;
        mem_wready = 1'b0;
        #2;
        check("rst_wvalid", mem_wvalid, 1'b0);
        check("rst_empty", wbuf_empty, 1'b1);
        check("rst_stall", stall_M, 1'b0);
        check("rst_rdata", readdataM, 32'hCAFE);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle();
        cyc();

        // Fill to DEPTH with RAM stalled, then a fifth store stalls until ready rises.
        log_addr.delete(); log_data.delete();
        mem_wready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            store(32'h10 + 32'(4 * i), 32'(i + 1));
            #1;
            check("fill_stall", stall_M, 1'b0);
            cyc();
        end
        idle();
        #1;
        check("fill_empty", wbuf_empty, 1'b0);
        check("fill_waddr", mem_waddr, 32'h10);
        check("fill_wdata", mem_wdata, 32'h1);
        store(32'h30, 32'h5);
        #1;
        check("full_stall", stall_M, 1'b1);
        cyc();
        check("full_stall_hold", stall_M, 1'b1);
        check("hold_waddr", mem_waddr, 32'h10);
        check("hold_wdata", mem_wdata, 32'h1);
        mem_wready = 1'b1;
        #1;
        check("full_pop_nostall", stall_M, 1'b0);
        cyc();
        drain(20);
        check("fill_wr_count", 32'(log_addr.size()), 32'd5);
        for (int i = 0; i < 4; i++) check_write("fill_wr", i, 32'h10 + 32'(4 * i), 32'(i + 1));
        check_write("fill_wr5", 4, 32'h30, 32'h5);

        // Two stores to one word, then loads: forwarding, miss path, memreadM low.
        log_addr.delete(); log_data.delete();
        mem_wready = 1'b0;
        store(32'h20, 32'hAAAA);
        cyc();
        store(32'h20, 32'hBBBB);
        cyc();
        idle();
        memreadM  = 1'b1;
        aluoutM   = 32'h22;
        mem_rdata = 32'h1234;
        #1;
        check("fwd_young", readdataM, 32'hBBBB);
        check("fwd_raddr", mem_raddr, 32'h20);
        aluoutM = 32'h40;
        #1;
        check("miss_rdata", readdataM, 32'h1234);
        check("miss_raddr", mem_raddr, 32'h40);
        memreadM = 1'b0;
        aluoutM  = 32'h20;
        #1;
        check("noread_rdata", readdataM, 32'h1234);
        drain(20);
`ifdef WBUF_COALESCE_EN
        check("coal_wr_count", 32'(log_addr.size()), 32'd1);
        check_write("coal_wr", 0, 32'h20, 32'hBBBB);
`else
        check("dup_wr_count", 32'(log_addr.size()), 32'd2);
        check_write("dup_wr0", 0, 32'h20, 32'hAAAA);
        check_write("dup_wr1", 1, 32'h20, 32'hBBBB);
`endif

        // Streaming with RAM always ready: each store drains one cycle after its push.
        log_addr.delete(); log_data.delete();
        mem_wready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            store(32'h100 + 32'(4 * i), 32'h50 + 32'(i));
            #1;
            check("b2b_stall", stall_M, 1'b0);
            if (i > 0) begin
                check("b2b_waddr", mem_waddr, 32'h100 + 32'(4 * (i - 1)));
                check("b2b_wdata", mem_wdata, 32'h50 + 32'(i - 1));
            end
            cyc();
        end
        idle();
        #1;
        check("b2b_last_wdata", mem_wdata, 32'h55);
        cyc();
        check("b2b_empty", wbuf_empty, 1'b1);
        check("b2b_wr_count", 32'(log_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) check_write("b2b_wr", i, 32'h100 + 32'(4 * i), 32'h50 + 32'(i));

        // Ten stores with ready toggling; load each address while still pending.
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 10; i++) begin
            store(32'h200 + 32'(4 * i), 32'h900 + 32'(i));
            mem_wready = 1'b1;
            #1;
            check("wrap_stall", stall_M, 1'b0);
            cyc();
            idle();
            mem_wready = 1'b0;
            memreadM   = 1'b1;
            aluoutM    = 32'h200 + 32'(4 * i);
            mem_rdata  = 32'hDEAD;
            #1;
            check("wrap_fwd", readdataM, 32'h900 + 32'(i));
            cyc();
        end
        drain(20);
        check("wrap_wr_count", 32'(log_addr.size()), 32'd10);
        for (int i = 0; i < 10; i++) check_write("wrap_wr", i, 32'h200 + 32'(4 * i), 32'h900 + 32'(i));

        // Reset in the middle of a drain discards pending stores.
        log_addr.delete(); log_data.delete();
        mem_wready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            store(32'h300 + 32'(4 * i), 32'h70 + 32'(i));
            cyc();
        end
        idle();
        #1;
        check("pre_rst_empty", wbuf_empty, 1'b0);
        mem_wready = 1'b1;
        reset      = 1'b0;
        #1;
        check("mid_rst_wvalid", mem_wvalid, 1'b0);
        check("mid_rst_empty", wbuf_empty, 1'b1);
        check("mid_rst_stall", stall_M, 1'b0);
        cyc();
        reset = 1'b1;
        repeat (4) cyc();
        check("post_rst_writes", 32'(log_addr.size()), 32'd0);
        check("post_rst_empty", wbuf_empty, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_wbuf.md
Name: dmem_wbuf

Overview:
- Store write buffer between the pipeline's memory stage and the data RAM.
- Accepts stores from M stage (memwriteM, aluoutM, writedataM) into a FIFO and drains them to the RAM write port over a valid/ready handshake.
- Services loads combinationally with store-to-load forwarding from the buffer, falling back to the RAM read port.
- Raises a stall toward the pipeline when a store arrives and the buffer is full.

Parameters:
DEPTH, 4, number of buffer entries; power of two, min 2
AW, 32, address width in bits (word address = AW-2 upper bits)

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
memwriteM  input  1  store request from M stage
memreadM  input  1  load request from M stage
aluoutM  input  AW  byte address of load/store
writedataM  input  32  store data
readdataM  output  32  load result to M/W pipeline register
stall_M  output  1  store cannot be accepted this cycle; pipeline holds F/D/E/M
mem_raddr  output  AW  RAM asynchronous read address, = {aluoutM[AW-1:2],2'b00}
mem_rdata  input  32  RAM read data, combinational from mem_raddr
mem_wvalid  output  1  head entry valid for drain
mem_waddr  output  AW  head entry word-aligned address
mem_wdata  output  32  head entry data
mem_wready  input  1  RAM accepts write this cycle
wbuf_empty  output  1  no entries pending (count==0)

Behaviour:
- Storage: DEPTH entries {valid, word_addr[AW-3:0], data[31:0]}; head/tail pointers log2(DEPTH) bits, wrap modulo DEPTH; count 0..DEPTH.
- reset low (async): head=tail=count=0, all valid=0, so mem_wvalid=0, stall_M=0, wbuf_empty=1. readdataM follows mem_rdata. Pending stores are discarded; reset mid-drain discards them too.
- Drain: mem_wvalid = (count!=0); mem_waddr/mem_wdata = head entry.
  - Pop on posedge when mem_wvalid && mem_wready: clear valid, head+1.
  - Entry data must stay stable while mem_wvalid=1 and mem_wready=0.
- Push: pop_now = mem_wvalid && mem_wready; full = (count==DEPTH).
  - accept = memwriteM && (!full || pop_now).
  - On accept: write entry at tail {1, aluoutM[AW-1:2], writedataM}, tail+1.
  - Push and pop in the same cycle leave count unchanged.
  - Full + pop + push same cycle: accepted, count stays DEPTH.
- stall_M = memwriteM && full && !mem_wready. Combinational, no registered latency. The store is re-presented next cycle and accepted once a slot frees.
- Loads: memreadM is combinational, zero latency.
  - Compare aluoutM[AW-1:2] against all valid entries.
  - If any match, readdataM = data of the youngest match (closest to tail-1, wrap-aware); otherwise readdataM = mem_rdata.
  - An entry being popped this cycle still forwards this cycle.
  - A store accepted this cycle is not visible to a load in the same cycle.
  - memreadM=0: readdataM = mem_rdata (don't care to pipeline).
- Byte offset aluoutM[1:0] is ignored; word stores only.
- memwriteM && memreadM together: illegal, not checked.
- Order: strict FIFO drain; RAM sees stores in program order.

Optional Feature:
WBUF_COALESCE_EN
- Defined: a store whose word address matches the youngest valid entry (tail-1) overwrites that entry's data instead of allocating, unless that entry is the head with mem_wvalid && mem_wready this cycle (then allocate normally).
  - A coalescing store never stalls, even when full.
- Undefined: every accepted store allocates a new entry; no address comparison on the push path.

Test Plan:
- Reset low mid-drain with count=3 -> mem_wvalid=0, wbuf_empty=1, stall_M=0 immediately; after release no writes of old entries occur.
- mem_wready=0; stores to 0x10, 0x14, 0x18, 0x1C (data 1..4) -> count=4, wbuf_empty=0.
  - Fifth store -> stall_M=1 while mem_wready=0.
  - Raise mem_wready -> fifth store accepted the same cycle; RAM receives 1, 2, 3, 4, 5 in order at 0x10 ... 0x1C, then the fifth store's address.
- mem_wready=0; store 0x20=0xAAAA then 0x20=0xBBBB; load 0x22 -> readdataM=0xBBBB (youngest match, offset ignored). With WBUF_COALESCE_EN: count=1 and only 0xBBBB is written.
- Load 0x40 with no match and mem_rdata=0x1234 -> readdataM=0x1234, mem_raddr=0x40.
- Empty buffer, mem_wready=1 always; back-to-back stores every cycle -> never stall; each store is written one cycle after its push; count ≤ 1.
- Wrap: 10 stores with mem_wready toggling 1 of 2 cycles -> pointers wrap correctly; all 10 writes reach RAM in order; a load of each address, issued while it is pending, returns its data.
